// File: rtl/bram_sdp_fifo_ctrl_if.sv
// Bundles the upstream sink, downstream source and both BRAM port signals of the FIFO controller.
interface bram_sdp_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int BE_WIDTH   = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH+1:0] count;
  logic                  wen;
  logic [BE_WIDTH-1:0]   wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rdata;

  modport slave (
    input  in_valid, in_data, out_ready, rdata,
    output in_ready, out_valid, out_data, count,
           wen, wr_be, wr_addr, wdata, ren, rd_addr
  );

  modport master (
    output in_valid, in_data, out_ready, rdata,
    input  in_ready, out_valid, out_data, count,
           wen, wr_be, wr_addr, wdata, ren, rd_addr
  );
endinterface

// File: rtl/bram_sdp_fifo_ctrl.sv
// Single-clock FIFO controller over one simple-dual-port BRAM half, with a 2-entry
// output buffer that hides the 1-cycle BRAM read latency.
module bram_sdp_fifo_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18,
  parameter int BE_WIDTH   = 2
) (
  input logic                 clk,
  input logic                 rst,
  bram_sdp_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] RAM_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   ram_cnt_nxt;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail_nxt;
  logic [ADDR_WIDTH+1:0] count_q;
  logic [ADDR_WIDTH+1:0] count_nxt;
  logic                  push;
  logic                  pop;
  logic                  ren;
  logic [2:0]            buf_pending;

  assign bus.in_ready = !rst && (ram_cnt != RAM_FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.wen      = push;
  assign bus.wr_be    = '1;
  assign bus.wr_addr  = wr_ptr;
  assign bus.wdata    = bus.in_data;

  assign bus.out_valid = (buf_cnt != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = buf_head;
  assign bus.count     = count_q;

  // Words already in the buffer or on their way, after this cycle's pop; never overcommit past 2.
  assign buf_pending = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ren         = (ram_cnt != '0) && (buf_pending < 3'd2);
  assign bus.ren     = ren;
  assign bus.rd_addr = rd_ptr;

  assign ram_cnt_nxt = ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(ren);

  always_comb begin
    head_nxt    = buf_head;
    tail_nxt    = buf_tail;
    buf_cnt_nxt = buf_cnt;
    case ({inflight, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) head_nxt = bus.rdata;
        else                 tail_nxt = bus.rdata;
        buf_cnt_nxt = buf_cnt + 2'd1;
      end
      2'b01: begin
        head_nxt    = buf_tail;
        buf_cnt_nxt = buf_cnt - 2'd1;
      end
      2'b11: begin
        // Capture replaces the popped word; occupancy unchanged.
        if (buf_cnt == 2'd1) begin
          head_nxt = bus.rdata;
        end else begin
          head_nxt = buf_tail;
          tail_nxt = bus.rdata;
        end
      end
      default: ;
    endcase
  end

  assign count_nxt = (ADDR_WIDTH+2)'(ram_cnt_nxt) + (ADDR_WIDTH+2)'(ren)
                   + (ADDR_WIDTH+2)'(buf_cnt_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      buf_cnt  <= 2'd0;
      buf_head <= '0;
      buf_tail <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (ren)  rd_ptr <= rd_ptr + 1'b1;
      ram_cnt  <= ram_cnt_nxt;
      inflight <= ren;
      buf_cnt  <= buf_cnt_nxt;
      buf_head <= head_nxt;
      buf_tail <= tail_nxt;
      count_q  <= count_nxt;
    end
  end
endmodule

// File: doc/bram_sdp_fifo_ctrl.md
# bram_sdp_fifo_ctrl

Single-clock FIFO controller that owns one simple-dual-port half of a RAM_18K_X2_BLK. It is the initiator on both the BRAM write port and the BRAM read port. Upstream it presents a valid/ready sink and downstream a valid/ready source. A 2-entry output buffer hides the 1-cycle BRAM read latency and sustains one word per cycle.

## Interface
- ADDR_WIDTH, 10, BRAM address width; RAM capacity 2^ADDR_WIDTH words
- DATA_WIDTH, 18, word width (9 or 18)
- BE_WIDTH, 2, byte-enable width (1 for 9-bit, 2 for 18-bit)

- clock0  in  1  single clock for the block and both BRAM ports (WR/RD clocks tied to it)
- RESET_i  in  1  asynchronous, active-high reset
- IN_VALID_i  in  1  upstream word valid
- IN_READY_o  out  1  controller can accept a word
- IN_DATA_i  in  DATA_WIDTH  upstream word
- OUT_VALID_o  out  1  head word valid
- OUT_READY_i  in  1  downstream accepts head word
- OUT_DATA_o  out  DATA_WIDTH  head word
- COUNT_o  out  ADDR_WIDTH+2  total occupancy
- WEN_o  out  1  BRAM write enable
- WR_BE_o  out  BE_WIDTH  BRAM byte enables, constant all-ones
- WR_ADDR_o  out  ADDR_WIDTH  BRAM write address
- WDATA_o  out  DATA_WIDTH  BRAM write data
- REN_o  out  1  BRAM read enable
- RD_ADDR_o  out  ADDR_WIDTH  BRAM read address
- RDATA_i  in  DATA_WIDTH  BRAM read data, valid the cycle after REN_o

## Operation
- State:
  - wr_ptr and rd_ptr, ADDR_WIDTH bits each, wrapping naturally at 2^ADDR_WIDTH.
  - ram_cnt, ADDR_WIDTH+1 bits: words written and not yet read.
  - inflight, 1 bit: a read was issued last cycle.
  - Output buffer: 2 entries, buf_cnt 0..2, FIFO order.
- Push: push = IN_VALID_i & IN_READY_o. IN_READY_o = !RESET_i & (ram_cnt != 2^ADDR_WIDTH).
  - WEN_o = push, WR_ADDR_o = wr_ptr, WDATA_o = IN_DATA_i, all combinational.
  - wr_ptr increments on push.
- Pop: pop = OUT_VALID_o & OUT_READY_i. OUT_VALID_o = (buf_cnt != 0). OUT_DATA_o = buffer head.
- Read issue: REN_o = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2). RD_ADDR_o = rd_ptr.
  - rd_ptr increments on REN_o.
  - inflight <= REN_o.
- Capture: when inflight = 1, RDATA_i is written into the buffer tail at the clock edge.
  - A capture and a pop in the same cycle leave buf_cnt unchanged.
  - With buf_cnt = 1, capture plus pop shifts the captured word into the head.
- ram_cnt update: ram_cnt <= ram_cnt + push - REN_o.
  - A simultaneous push and REN leaves it unchanged.
  - REN never targets the word being written in that same cycle, because ram_cnt excludes it.
- COUNT_o = ram_cnt + inflight + buf_cnt, registered, reflecting state after the edge.
- Word order is strictly preserved. There are no overflow or underflow states: IN_READY_o and OUT_VALID_o gate all transfers.
- Reset, asynchronous at any time:
  - Pointers, ram_cnt, inflight, buf_cnt and COUNT_o go to 0.
  - OUT_VALID_o = 0, REN_o = 0, WEN_o = 0, IN_READY_o = 0 while RESET_i is high and 1 after release.
  - An in-flight read is discarded. BRAM contents are left stale and are unreachable.
  - OUT_DATA_o resets to 0.

## Timing
- WEN_o, WR_ADDR_o and WDATA_o are combinational from the inputs. REN_o is combinational from state and OUT_READY_i.
- First-word latency: a word accepted at edge N gives REN_o high in cycle N+1 and RDATA_i valid in cycle N+2. It is captured at the end of N+2, so OUT_VALID_o is high from cycle N+3.
- Steady state with IN_VALID_i = 1 and OUT_READY_i = 1: one push and one pop per cycle, no bubbles after the initial 3-cycle fill.
- Full: after 2^ADDR_WIDTH words with no reads issued, IN_READY_o = 0.
  - Maximum COUNT_o is 2^ADDR_WIDTH + 2, because the buffer holds 2 more words.
  - In the cycle a REN frees a slot, IN_READY_o rises the next cycle. There is no same-cycle full bypass.
- Downstream stall (OUT_READY_i = 0): at most 2 words are prefetched into the buffer. REN_o stays low after that until a pop.
- Pointer wrap: address 2^ADDR_WIDTH - 1 is followed by 0 on both ports.

## Test plan
- Reset, then push 0x00001, 0x00002, 0x00003 on consecutive edges with OUT_READY_i = 1.
  - Required: OUT_VALID_o first high 3 cycles after the first accept.
  - OUT_DATA_o reads 1, 2, 3 on consecutive cycles; COUNT_o returns to 0.
- Hold OUT_READY_i = 0 and push 1026 words (values 0..1025).
  - Required: IN_READY_o falls after 1026 accepts; COUNT_o = 1026; REN_o is issued exactly twice.
- From full, raise OUT_READY_i.
  - Required: 1026 words out in order 0..1025, one per cycle after a 1-cycle restart bubble at most; IN_READY_o = 1 the cycle after the first REN.
- Continuous streaming of 3000 words with IN_VALID_i = OUT_READY_i = 1.
  - Required: WR_ADDR_o and RD_ADDR_o wrap 1023 -> 0; data matches in order; no lost cycles after fill.
- Random IN_VALID_i / OUT_READY_i for 10k cycles.
  - Required: scoreboard order match; COUNT_o equals pushes minus pops every cycle.
- Assert RESET_i mid-stream while inflight = 1.
  - Required: OUT_VALID_o = 0 and COUNT_o = 0 immediately.
  - After release, a new push of 0x2AAAA is the first word out.
